// File: rtl/pe_ec_seq.sv
// Sequential binary conv / max-pool / binarize PE: serial XNOR-popcount over pool positions, DSLICE channels per cycle.
// Optional feature macro: PE_EC_SCORE_OUT_EN adds the score_out port carrying the registered max score.
module pe_ec_seq #(
  parameter  int D             = 512,
  parameter  int DSLICE        = 64,
  parameter  int FH            = 3,
  parameter  int FW            = 3,
  parameter  int POOL_H        = 2,
  parameter  int POOL_W        = 2,
  parameter  int STRIDE_H      = 1,
  parameter  int STRIDE_W      = 1,
  parameter  int NORMREF_WIDTH = 14,
  localparam int IN_WINDOW_H   = (POOL_H - 1) * STRIDE_H + FH,
  localparam int IN_WINDOW_W   = (POOL_W - 1) * STRIDE_W + FW,
  localparam int N_KERNEL      = POOL_H * POOL_W,
  localparam int N_SLICE       = D / DSLICE,
  localparam int PINDEX_WIDTH  = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1,
  localparam int SCORE_WIDTH   = $clog2(FH * FW * D + 1),
  localparam int DATA_W        = D * IN_WINDOW_H * IN_WINDOW_W,
  localparam int WEIGHT_W      = D * FH * FW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [WEIGHT_W-1:0]      weight_in,
  input  logic [NORMREF_WIDTH-1:0] norm_ref,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_KERNEL-1:0]      data_out_vec,
  output logic [PINDEX_WIDTH-1:0]  pindex
`ifdef PE_EC_SCORE_OUT_EN
  ,
  output logic [SCORE_WIDTH-1:0]   score_out
`endif
);

  localparam int SLICE_IDX_W = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
  localparam int CW          = SCORE_WIDTH + 2;
  localparam int TOTAL       = FH * FW * D;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_BIN, S_OUT} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]               data_q;
  logic [WEIGHT_W-1:0]             weight_q;
  logic signed [NORMREF_WIDTH-1:0] norm_q;
  logic [PINDEX_WIDTH-1:0]         p_q;
  logic [SLICE_IDX_W-1:0]          s_q;
  logic [SCORE_WIDTH-1:0]          acc_q;
  logic [SCORE_WIDTH-1:0]          max_q;
  logic [PINDEX_WIDTH-1:0]         idx_q;

  logic [SCORE_WIDTH-1:0] slice_cnt;
  logic [SCORE_WIDTH-1:0] score;
  logic [DSLICE-1:0]      xn;
  logic                   last_slice;
  logic                   last_pos;
  logic                   accept;
  logic signed [CW-1:0]   lhs;
  logic signed [CW-1:0]   rhs;
  logic                   bin_bit;
  int                     pos_i;
  int                     pos_j;
  int                     q;
  int                     dbase;
  int                     wbase;

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign accept     = in_valid && in_ready;
  assign last_slice = (s_q == SLICE_IDX_W'(N_SLICE - 1));
  assign last_pos   = (p_q == PINDEX_WIDTH'(N_KERNEL - 1));
  assign score      = acc_q + slice_cnt;

  // Popcount of XNOR over slice s of every filter tap under pool position p.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    slice_cnt = '0;
    xn        = '0;
    q         = 0;
    dbase     = 0;
    wbase     = 0;
    pos_i     = int'(p_q) / POOL_W;
    pos_j     = int'(p_q) % POOL_W;
    for (int m = 0; m < FH; m++) begin
      for (int n = 0; n < FW; n++) begin
        q     = (pos_i * STRIDE_H + m) * IN_WINDOW_W + (pos_j * STRIDE_W + n);
        dbase = DATA_W - 1 - D * q - int'(s_q) * DSLICE;
        wbase = WEIGHT_W - 1 - D * (m * FW + n) - int'(s_q) * DSLICE;
        xn    = ~(data_q[dbase -: DSLICE] ^ weight_q[wbase -: DSLICE]);
        for (int b = 0; b < DSLICE; b++) begin
          slice_cnt = slice_cnt + SCORE_WIDTH'(xn[b]);
        end
      end
    end
  end

  // Binarize: 2*max > FH*FW*D + norm_ref, evaluated signed with headroom for both operands.
  always_comb begin
    lhs     = signed'({1'b0, max_q, 1'b0});
    rhs     = CW'(TOTAL) + CW'(norm_q);
    bin_bit = (lhs > rhs);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_CONV;
      S_CONV: if (last_slice && last_pos) state_d = S_BIN;
      S_BIN:  state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the wide operand/accumulator registers are not reset; each accept reloads or clears them,
  // so stale contents after a reset can never reach an output.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q   <= data_in;
      weight_q <= weight_in;
      norm_q   <= norm_ref;
      p_q      <= '0;
      s_q      <= '0;
      acc_q    <= '0;
      max_q    <= '0;
      idx_q    <= '0;
    end else if (state_q == S_CONV) begin
      if (last_slice) begin
        // Strict compare keeps the lowest position on ties; position 0 always seeds the max.
        if (p_q == '0 || score > max_q) begin
          max_q <= score;
          idx_q <= p_q;
        end
        acc_q <= '0;
        s_q   <= '0;
        p_q   <= p_q + 1'b1;
      end else begin
        acc_q <= score;
        s_q   <= s_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_vec <= '0;
      pindex       <= '0;
    end else if (state_q == S_BIN) begin
      data_out_vec <= N_KERNEL'(bin_bit) << idx_q;
      pindex       <= idx_q;
    end
  end

`ifdef PE_EC_SCORE_OUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                  score_out <= '0;
    else if (state_q == S_BIN)   score_out <= max_q;
  end
`endif

endmodule
